// File: rtl/aes_pkg.sv
// Shared encodings and constants for the AES-128 round controller.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned NUM_STEPS  = 40;
  localparam int unsigned STEP_W     = 6;

  // Datapath step select presented on dp_op.
  typedef enum logic [1:0] {
    OpSub    = 2'd0,
    OpShift  = 2'd1,
    OpMix    = 2'd2,
    OpAddKey = 2'd3
  } dp_op_e;

  // Controller FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/aes_step_decode.sv
// Maps the step counter and direction onto the datapath step and round-key index.
module aes_step_decode
  import aes_pkg::*;
(
  input  logic [STEP_W-1:0] step_i,
  input  logic              encrypt_i,
  output dp_op_e            op_o,
  output logic [3:0]        round_o
);

  logic [STEP_W-1:0] step_m1;
  logic [3:0]        grp;
  logic [1:0]        phase;

  // Step 0 is the initial key add; the remaining steps fall into groups of four.
  always_comb begin
    step_m1 = step_i - 6'd1;
    grp     = step_m1[5:2];
    phase   = step_m1[1:0];
    op_o    = OpAddKey;
    round_o = 4'd0;
    if (encrypt_i) begin
      if (step_i == '0) begin
        op_o    = OpAddKey;
        round_o = 4'd0;
      end else begin
        round_o = grp + 4'd1;
        unique case (phase)
          2'd0:    op_o = OpSub;
          2'd1:    op_o = OpShift;
          // The last round has no MixColumns: its third step is the key add.
          2'd2:    op_o = (grp == 4'(NUM_ROUNDS - 1)) ? OpAddKey : OpMix;
          default: op_o = OpAddKey;
        endcase
      end
    end else begin
      if (step_i == '0) begin
        op_o    = OpAddKey;
        round_o = 4'(NUM_ROUNDS);
      end else begin
        // Group 9 only reaches phase 2, so the final round never issues MIX.
        round_o = 4'd9 - grp;
        unique case (phase)
          2'd0:    op_o = OpShift;
          2'd1:    op_o = OpSub;
          2'd2:    op_o = OpAddKey;
          default: op_o = OpMix;
        endcase
      end
    end
  end

endmodule

// File: rtl/aes_round_controller.sv
// AES-128 round sequencer: steps an external round datapath through 40 steps per block.
module aes_round_controller
  import aes_pkg::*;
(
  input  logic         clock,
  input  logic         n_rst,
  input  logic         start,
  input  logic         encrypt,
  input  logic [127:0] data_in,
  input  logic [127:0] dp_result,
  output logic [127:0] dp_state,
  output logic [1:0]   dp_op,
  output logic         dp_encrypt,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);

  ctrl_state_e       ctrl_q, ctrl_d;
  logic [127:0]      state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              enc_q, enc_d;
  logic [127:0]      dout_q, dout_d;

  dp_op_e            dec_op;
  logic [3:0]        dec_round;
  logic              run;

  aes_step_decode u_step_decode (
    .step_i    (step_q),
    .encrypt_i (enc_q),
    .op_o      (dec_op),
    .round_o   (dec_round)
  );

  // State register and datapath-facing flops.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      ctrl_q  <= StIdle;
      state_q <= '0;
      step_q  <= '0;
      enc_q   <= 1'b1;
      dout_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
      step_q  <= step_d;
      enc_q   <= enc_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state logic: accept in IDLE, one datapath step per RUN cycle, one-cycle DONE.
  always_comb begin
    ctrl_d  = ctrl_q;
    state_d = state_q;
    step_d  = step_q;
    enc_d   = enc_q;
    dout_d  = dout_q;
    unique case (ctrl_q)
      StIdle: begin
        if (start) begin
          state_d = data_in;
          enc_d   = encrypt;
          step_d  = '0;
          ctrl_d  = StRun;
        end
      end
      StRun: begin
        state_d = dp_result;
        step_d  = step_q + 6'd1;
        if (step_q == 6'(NUM_STEPS - 1)) begin
          dout_d = dp_result;
          ctrl_d = StDone;
        end
      end
      StDone: ctrl_d = StIdle;
      default: ctrl_d = StIdle;
    endcase
  end

  // Outputs: decoded step only while running, reset-like defaults otherwise.
  always_comb begin
    run        = (ctrl_q == StRun);
    dp_state   = state_q;
    dp_op      = run ? dec_op : OpAddKey;
    round_idx  = run ? dec_round : 4'd0;
    dp_encrypt = enc_q;
    busy       = (ctrl_q != StIdle);
    done       = (ctrl_q == StDone);
    data_out   = dout_q;
  end

endmodule

// File: tb/tb_aes_round_controller.sv
// Self-checking bench: AES-128 round datapath model around the controller, scoreboard on done.
module tb_aes_round_controller;

  logic         clock = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic         encrypt = 1'b1;
  logic [127:0] data_in = '0;
  logic [127:0] dp_result;
  logic [127:0] dp_state;
  logic [1:0]   dp_op;
  logic         dp_encrypt;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;
  logic [127:0] data_out;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

  aes_round_controller dut (
    .clock      (clock),
    .n_rst      (n_rst),
    .start      (start),
    .encrypt    (encrypt),
    .data_in    (data_in),
    .dp_result  (dp_result),
    .dp_state   (dp_state),
    .dp_op      (dp_op),
    .dp_encrypt (dp_encrypt),
    .round_idx  (round_idx),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- datapath model ----------------
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [11];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] dp_model(input logic [127:0] s, input logic [1:0] op,
                                            input logic enc, input logic [3:0] rnd);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    int           src;
    r = s;
    case (op)
      2'd0: for (int i = 0; i < 16; i++)
        r[127-8*i -: 8] = enc ? sbox[s[127-8*i -: 8]] : isbox[s[127-8*i -: 8]];
      2'd1: for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 4; k++) begin
          src = enc ? (c + k) % 4 : (c - k + 4) % 4;
          r[127-8*(4*c+k) -: 8] = s[127-8*(4*src+k) -: 8];
        end
      end
      2'd2: for (int c = 0; c < 4; c++) begin
        a0 = s[127-32*c -: 8];
        a1 = s[119-32*c -: 8];
        a2 = s[111-32*c -: 8];
        a3 = s[103-32*c -: 8];
        if (enc)
          r[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                               a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                               a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                               gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
        else
          r[127-32*c -: 32] = {gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
                               gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
                               gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
                               gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
      end
      default: if (rnd <= 4'd10) r = s ^ rk[int'(rnd)];
    endcase
    return r;
  endfunction

  assign dp_result = dp_model(dp_state, dp_op, dp_encrypt, round_idx);

  // S-box from GF(2^8) inverse plus affine map; key schedule for the fixed key.
  task automatic build_tables();
    logic [7:0]  inv, x;
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      x = inv;
      sbox[a] = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) isbox[sbox[a]] = 8'(a);
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- expected step traces ----------------
  logic [1:0] e_op [40];
  logic [3:0] e_rd [40];
  logic [1:0] d_op [40];
  logic [3:0] d_rd [40];

  task automatic build_traces();
    int n;
    n = 0;
    e_op[n] = 2'd3; e_rd[n] = 4'd0; n++;
    for (int r = 1; r <= 9; r++) begin
      e_op[n] = 2'd0; e_rd[n] = 4'(r); n++;
      e_op[n] = 2'd1; e_rd[n] = 4'(r); n++;
      e_op[n] = 2'd2; e_rd[n] = 4'(r); n++;
      e_op[n] = 2'd3; e_rd[n] = 4'(r); n++;
    end
    e_op[n] = 2'd0; e_rd[n] = 4'd10; n++;
    e_op[n] = 2'd1; e_rd[n] = 4'd10; n++;
    e_op[n] = 2'd3; e_rd[n] = 4'd10;
    n = 0;
    d_op[n] = 2'd3; d_rd[n] = 4'd10; n++;
    for (int r = 9; r >= 1; r--) begin
      d_op[n] = 2'd1; d_rd[n] = 4'(r); n++;
      d_op[n] = 2'd0; d_rd[n] = 4'(r); n++;
      d_op[n] = 2'd3; d_rd[n] = 4'(r); n++;
      d_op[n] = 2'd2; d_rd[n] = 4'(r); n++;
    end
    d_op[n] = 2'd1; d_rd[n] = 4'd0; n++;
    d_op[n] = 2'd0; d_rd[n] = 4'd0; n++;
    d_op[n] = 2'd3; d_rd[n] = 4'd0;
  endtask

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    logic [127:0] data;
    logic         enc;
    int           start_cyc;
  } exp_t;

  exp_t       exp_q [$];
  logic [1:0] tr_op [40];
  logic [3:0] tr_rd [40];
  logic       tr_en [40];
  int         tr_n = 0;
  logic       prev_done = 1'b0;

  initial begin : monitor
    exp_t e;
    int   bad;
    int   final_mix;
    forever begin
      @(negedge clock);
      if (!busy) begin
        tr_n = 0;
      end else if (!done) begin
        if (tr_n < 40) begin
          tr_op[tr_n] = dp_op;
          tr_rd[tr_n] = round_idx;
          tr_en[tr_n] = dp_encrypt;
        end
        tr_n++;
      end else begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {127'd0, done}, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", data_out, e.data);
          // start-sampling edge counts as the first cycle, so done shows 40 edges later
          chk("latency", 128'(cyc - e.start_cyc), 128'd40);
          chk("trace_len", 128'(tr_n), 128'd40);
          bad = 0;
          final_mix = 0;
          for (int i = 0; i < 40 && i < tr_n; i++) begin
            if (e.enc ? (tr_op[i] !== e_op[i] || tr_rd[i] !== e_rd[i])
                      : (tr_op[i] !== d_op[i] || tr_rd[i] !== d_rd[i])) bad++;
            if (tr_en[i] !== e.enc) bad++;
            if (tr_op[i] == 2'd2 && tr_rd[i] == (e.enc ? 4'd10 : 4'd0)) final_mix++;
          end
          chk("trace_steps", 128'(bad), 128'd0);
          chk("final_round_mix", 128'(final_mix), 128'd0);
        end
      end
      if (done && prev_done) chk("done_pulse_width", {127'd0, done}, 128'd0);
      prev_done = done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_op(input logic [127:0] d, input logic enc, input logic [127:0] exp,
                          input bit push);
    exp_t e;
    @(posedge clock); #1;
    data_in = d;
    encrypt = enc;
    start   = 1'b1;
    @(posedge clock); #1;
    if (push) begin
      e.data      = exp;
      e.enc       = enc;
      e.start_cyc = cyc;
      exp_q.push_back(e);
    end
    start   = 1'b0;
    // Scramble the sampled inputs; RUN must ignore them.
    data_in = ~d;
    encrypt = ~enc;
  endtask

  task automatic wait_done();
    int tgt;
    int n;
    tgt = done_cnt + 1;
    n = 0;
    while (done_cnt < tgt && n < 100) begin
      @(posedge clock); #2;
      n++;
    end
    chk("done_arrived", {127'd0, done_cnt >= tgt}, 128'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, {127'd0, busy}, 128'd0);
    chk({tag, "_done"}, {127'd0, done}, 128'd0);
    chk({tag, "_data_out"}, data_out, 128'd0);
    chk({tag, "_dp_state"}, dp_state, 128'd0);
    chk({tag, "_dp_op"}, {126'd0, dp_op}, 128'd3);
    chk({tag, "_dp_encrypt"}, {127'd0, dp_encrypt}, 128'd1);
    chk({tag, "_round_idx"}, {124'd0, round_idx}, 128'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int   d0;
    int   c0;
    exp_t e;
    build_tables();
    build_traces();
    #12;
    check_reset("por");
    @(negedge clock);
    n_rst = 1'b1;

    // Known-answer encrypt, then decrypt.
    start_op(PT, 1'b1, CT, 1'b1);
    wait_done();
    repeat (5) @(posedge clock);
    #1;
    chk("hold_after_enc", data_out, CT);
    chk("idle_busy", {127'd0, busy}, 128'd0);
    start_op(CT, 1'b0, PT, 1'b1);
    wait_done();

    // Start pulses during RUN are ignored.
    d0 = done_cnt;
    start_op(PT, 1'b1, CT, 1'b1);
    repeat (4) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    chk("ignored_start_busy5", {127'd0, busy}, 128'd1);
    repeat (14) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    chk("ignored_start_busy20", {127'd0, busy}, 128'd1);
    wait_done();
    repeat (10) @(posedge clock);
    #1;
    chk("single_done", 128'(done_cnt - d0), 128'd1);
    chk("hold_after_ignored", data_out, CT);

    // Asynchronous reset mid-operation aborts the block.
    d0 = done_cnt;
    start_op(PT, 1'b1, CT, 1'b0);
    repeat (16) @(posedge clock);
    #1;
    chk("busy_before_rst", {127'd0, busy}, 128'd1);
    #1 n_rst = 1'b0;
    #1;
    check_reset("async_rst");
    repeat (50) @(posedge clock);
    #1;
    chk("abort_no_done", 128'(done_cnt - d0), 128'd0);
    @(negedge clock);
    n_rst = 1'b1;
    start_op(PT, 1'b1, CT, 1'b1);
    wait_done();

    // Back-to-back with start held high: encrypt then decrypt.
    @(posedge clock); #1;
    data_in = PT;
    encrypt = 1'b1;
    start   = 1'b1;
    @(posedge clock); #1;
    c0 = cyc;
    e.data = CT; e.enc = 1'b1; e.start_cyc = c0;
    exp_q.push_back(e);
    // second block is sampled in the IDLE cycle right after DONE
    e.data = PT; e.enc = 1'b0; e.start_cyc = c0 + 42;
    exp_q.push_back(e);
    data_in = CT;
    encrypt = 1'b0;
    wait_done();
    wait_done();
    start = 1'b0;
    repeat (50) @(posedge clock);
    #1;
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    chk("final_idle", {127'd0, busy}, 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
